// File: rtl/axis_stat_sampler_pkg.sv
// ---------------------------------------------------------------------------
// easyobv_stat_pkg
// Shared definitions for the AXI-Stream statistics sampler:
//   - DROP_W        : width of the dropped-snapshot counter
//   - OFF_*         : field offsets inside a snapshot word, in units of CNT_W
//                     (drops sits at OFF_DROPS*CNT_W and is DROP_W wide)
//   - POP_MAX_W     : widest tkeep the popcount helper accepts
//   - POPCNT_W      : width of the popcount result
//   - state_t       : sampler FSM state encoding
//   - popcount()    : number of set bits in a (zero-extended) tkeep vector
// ---------------------------------------------------------------------------
package easyobv_stat_pkg;

  localparam int DROP_W     = 8;

  localparam int OFF_BEATS  = 0;
  localparam int OFF_PKTS   = 1;
  localparam int OFF_BYTES  = 2;
  localparam int OFF_STALLS = 3;
  localparam int OFF_DROPS  = 4;

  localparam int POP_MAX_W  = 256;
  localparam int POPCNT_W   = 9;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Callers zero-extend tkeep to POP_MAX_W so one helper serves every DATA_BYTES.
  function automatic logic [POPCNT_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
    logic [POPCNT_W-1:0] cnt;
    cnt = {POPCNT_W{1'b0}};
    for (int i = 0; i < POP_MAX_W; i++) begin
      cnt = cnt + POPCNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axis_stat_sampler_acc.sv
// ---------------------------------------------------------------------------
// stat_sat_acc
// One saturating statistics accumulator.
//   clk    in  1  clock
//   rst_n  in  1  asynchronous reset, active-low
//   inc_i  in  W  amount to add this cycle
//   clr_i  in  1  reload the accumulator to zero at the next edge
//   cap_o  out W  accumulator + inc_i, saturated at all-ones. This is the value
//                 the accumulator takes next cycle unless clr_i is set, and it is
//                 what the parent captures at a window boundary so the boundary
//                 cycle's event is neither lost nor counted twice.
// ---------------------------------------------------------------------------
module stat_sat_acc #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cap_o
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;
  logic [W:0]   sum_s;

  // Saturating add: the extra carry bit flags overflow past all-ones.
  always_comb begin
    sum_s = {1'b0, acc_q} + {1'b0, inc_i};
    if (sum_s[W]) begin
      cap_o = {W{1'b1}};
    end else begin
      cap_o = sum_s[W-1:0];
    end
  end

  // Next accumulator value: reload on clear, otherwise keep the saturated sum.
  always_comb begin
    if (clr_i) begin
      acc_d = {W{1'b0}};
    end else begin
      acc_d = cap_o;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= {W{1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/axis_stat_sampler.sv
// ---------------------------------------------------------------------------
// axis_stat_sampler
// Passive AXI-Stream tap that accumulates beats, packets, bytes and stall
// cycles over a window of WINDOW clocks and emits one snapshot per window over
// a valid/ready handshake (consumed by a multi-bit CDC synchroniser).
//   clk        in   1             monitored stream clock
//   rst_n      in   1             asynchronous reset, active-low
//   en         in   1             sampling enable (level)
//   s_tvalid   in   1             tapped tvalid
//   s_tready   in   1             tapped tready
//   s_tlast    in   1             tapped tlast
//   s_tkeep    in   DATA_BYTES    tapped tkeep
//   snap_data  out  4*CNT_W+8     {drops, stalls, bytes, pkts, beats}
//   snap_vld   out  1             snapshot valid
//   snap_rdy   in   1             snapshot accepted when snap_vld & snap_rdy
// snap_data never changes while a snapshot is offered and unaccepted; a
// window ending while the slot is occupied is discarded and counted in drops.
// ---------------------------------------------------------------------------
module axis_stat_sampler
  import easyobv_stat_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int CNT_W      = 32,
  parameter int WINDOW     = 1000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      s_tvalid,
  input  logic                      s_tready,
  input  logic                      s_tlast,
  input  logic [DATA_BYTES-1:0]     s_tkeep,
  output logic [4*CNT_W+DROP_W-1:0] snap_data,
  output logic                      snap_vld,
  input  logic                      snap_rdy
);

  localparam int SNAP_W = 4*CNT_W + DROP_W;
  localparam int WCNT_W = $clog2(WINDOW);
  localparam int EXT_W  = (CNT_W > POPCNT_W) ? CNT_W : POPCNT_W;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WINDOW - 1);

  state_t              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [DROP_W-1:0]   drops_q, drops_d;
  logic                snap_vld_q, snap_vld_d;
  logic [SNAP_W-1:0]   snap_data_q, snap_data_d;

  logic                beat_s, pkt_s, stall_s;
  logic                counting_s, capture_s, acc_clr_s, slot_free_s;
  logic [POPCNT_W-1:0] keep_cnt_s;
  logic [EXT_W-1:0]    keep_ext_s;
  logic [CNT_W-1:0]    beats_inc_s, pkts_inc_s, bytes_inc_s, stalls_inc_s;
  logic [CNT_W-1:0]    beats_cap_s, pkts_cap_s, bytes_cap_s, stalls_cap_s;
  logic [SNAP_W-1:0]   snap_val_s;

  assign beat_s  = s_tvalid & s_tready;
  assign pkt_s   = beat_s & s_tlast;
  assign stall_s = s_tvalid & ~s_tready;

  // The en=0 cycle of a RUN window is part of the discarded partial window,
  // so neither counting nor capture happens in it.
  assign counting_s  = (state_q == RUN) & en;
  assign capture_s   = counting_s & (wcnt_q == WCNT_LAST);
  assign acc_clr_s   = ~counting_s | capture_s;
  assign slot_free_s = ~snap_vld_q | snap_rdy;

  assign keep_cnt_s   = popcount(POP_MAX_W'(s_tkeep));
  assign beats_inc_s  = CNT_W'(beat_s);
  assign pkts_inc_s   = CNT_W'(pkt_s);
  assign stalls_inc_s = CNT_W'(stall_s);

  // Byte increment, clamped so a narrow CNT_W still saturates instead of truncating.
  always_comb begin
    keep_ext_s = EXT_W'(keep_cnt_s);
    if (!beat_s) begin
      bytes_inc_s = {CNT_W{1'b0}};
    end else if (keep_ext_s > EXT_W'({CNT_W{1'b1}})) begin
      bytes_inc_s = {CNT_W{1'b1}};
    end else begin
      bytes_inc_s = CNT_W'(keep_ext_s);
    end
  end

  stat_sat_acc #(.W(CNT_W)) u_acc_beats (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (beats_inc_s),
    .clr_i (acc_clr_s),
    .cap_o (beats_cap_s)
  );

  stat_sat_acc #(.W(CNT_W)) u_acc_pkts (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (pkts_inc_s),
    .clr_i (acc_clr_s),
    .cap_o (pkts_cap_s)
  );

  stat_sat_acc #(.W(CNT_W)) u_acc_bytes (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (bytes_inc_s),
    .clr_i (acc_clr_s),
    .cap_o (bytes_cap_s)
  );

  stat_sat_acc #(.W(CNT_W)) u_acc_stalls (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (stalls_inc_s),
    .clr_i (acc_clr_s),
    .cap_o (stalls_cap_s)
  );

  // Assemble the candidate snapshot from the accumulators' capture values.
  always_comb begin
    snap_val_s = {SNAP_W{1'b0}};
    snap_val_s[OFF_BEATS*CNT_W  +: CNT_W]  = beats_cap_s;
    snap_val_s[OFF_PKTS*CNT_W   +: CNT_W]  = pkts_cap_s;
    snap_val_s[OFF_BYTES*CNT_W  +: CNT_W]  = bytes_cap_s;
    snap_val_s[OFF_STALLS*CNT_W +: CNT_W]  = stalls_cap_s;
    snap_val_s[OFF_DROPS*CNT_W  +: DROP_W] = drops_q;
  end

  // FSM and window counter next state.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        wcnt_d = {WCNT_W{1'b0}};
        if (en) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          wcnt_d  = {WCNT_W{1'b0}};
        end else if (capture_s) begin
          state_d = RUN;
          wcnt_d  = {WCNT_W{1'b0}};
        end else begin
          state_d = RUN;
          wcnt_d  = wcnt_q + WCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = {WCNT_W{1'b0}};
      end
    endcase
  end

  // Snapshot slot and drop counter next state. A blocked capture leaves the
  // held snapshot untouched so the CDC consumer always sees stable data.
  always_comb begin
    snap_vld_d  = snap_vld_q;
    snap_data_d = snap_data_q;
    drops_d     = drops_q;
    if (capture_s && slot_free_s) begin
      snap_vld_d  = 1'b1;
      snap_data_d = snap_val_s;
      drops_d     = {DROP_W{1'b0}};
    end else if (capture_s) begin
      if (drops_q == {DROP_W{1'b1}}) begin
        drops_d = drops_q;
      end else begin
        drops_d = drops_q + DROP_W'(1);
      end
    end else if (snap_vld_q && snap_rdy) begin
      snap_vld_d = 1'b0;
    end else begin
      snap_vld_d = snap_vld_q;
    end
  end

  // State, window counter, drop counter and snapshot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wcnt_q      <= {WCNT_W{1'b0}};
      drops_q     <= {DROP_W{1'b0}};
      snap_vld_q  <= 1'b0;
      snap_data_q <= {SNAP_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      drops_q     <= drops_d;
      snap_vld_q  <= snap_vld_d;
      snap_data_q <= snap_data_d;
    end
  end

  assign snap_vld  = snap_vld_q;
  assign snap_data = snap_data_q;

endmodule
